// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// vram_pkg : shared types, slot defaults and byte-merge helper for the
//            68000-side video RAM port.   Rev 1.0
// ============================================================================
package vram_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SLOT = 3'd1,
    RD_ACCESS = 3'd2,
    WR_ACCESS = 3'd3,
    RMW_WAIT  = 3'd4,
    ACK       = 3'd5
  } vram_cpu_state_t;

  localparam logic [2:0] CPU_SLOT_DEFAULT    = 3'b000;
  localparam logic [2:0] STROBE_SLOT_DEFAULT = 3'b100;

  // Replace the byte lanes whose active-low strobe is asserted.
  function automatic logic [15:0] byte_merge(input logic [15:0] old_word,
                                             input logic [15:0] new_word,
                                             input logic        uds_b,
                                             input logic        lds_b);
    logic [15:0] merged;
    merged = old_word;
    if (!uds_b) merged[15:8] = new_word[15:8];
    if (!lds_b) merged[7:0]  = new_word[7:0];
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_slot_timer.sv
`default_nettype none
// ============================================================================
// vram_slot_timer : decodes the VRAC slot counter into one-cycle slot_start
//                   and strobe pulses.   Rev 1.0
// ============================================================================
module vram_slot_timer
  import vram_pkg::*;
#(
  parameter logic [2:0] CPU_SLOT    = CPU_SLOT_DEFAULT,
  parameter logic [2:0] STROBE_SLOT = STROBE_SLOT_DEFAULT
) (
  input  logic [2:0] vrac,
  output logic       slot_start,
  output logic       strobe
);

  // VRAC steps every clock, so each compare is true for exactly one cycle.
  assign slot_start = (vrac == CPU_SLOT);
  assign strobe     = (vrac == STROBE_SLOT);

endmodule
`default_nettype wire

// File: rtl/vram_cpu_port.sv
`default_nettype none
// ============================================================================
// vram_cpu_port : 68000 initiator into the playfield/alpha VRAM; byte writes
//                 are read-modify-write over two CPU slots.
// Option macro  : VRAM_CPU_POSTED_WRITE_EN (one-entry posted write buffer)
// Rev 1.0
// ============================================================================
module vram_cpu_port
  import vram_pkg::*;
#(
  parameter int         ADDR_W      = 13,
  parameter logic [2:0] CPU_SLOT    = CPU_SLOT_DEFAULT,
  parameter logic [2:0] STROBE_SLOT = STROBE_SLOT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_uds_b,
  input  logic              cpu_lds_b,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  input  logic [2:0]        VRAC,
  output logic [ADDR_W-1:0] MA,
  output logic              VRAMWR,
  output logic              VRAMRD_b,
  output logic [15:0]       VRD_out,
  output logic              VRD_oe,
  input  logic [15:0]       VRD_in
);

  vram_cpu_state_t   state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q, uds_b_q, lds_b_q;
  logic [15:0]       wdata_q, wr_word, rdata_q;
  logic              slot_start, strobe;
  logic              no_strobe, need_read, rd_phase, wr_phase;
  logic              posted_q, posted_ack_q, fwd_hit;

  vram_slot_timer #(
    .CPU_SLOT    (CPU_SLOT),
    .STROBE_SLOT (STROBE_SLOT)
  ) u_slot_timer (
    .vrac       (VRAC),
    .slot_start (slot_start),
    .strobe     (strobe)
  );

  assign no_strobe = cpu_uds_b & cpu_lds_b;
  // A single-byte write has to fetch the other byte first.
  assign need_read = rw_q | (uds_b_q ^ lds_b_q);

`ifdef VRAM_CPU_POSTED_WRITE_EN
  assign fwd_hit = posted_q & cpu_req & cpu_rw & ~no_strobe & (cpu_addr == addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      posted_q     <= 1'b0;
      posted_ack_q <= 1'b0;
    end else begin
      posted_ack_q <= (state == IDLE) & cpu_req & ~cpu_rw & ~no_strobe;
      if ((state == IDLE) && cpu_req && !cpu_rw && !no_strobe)
        posted_q <= 1'b1;
      else if (state == ACK)
        posted_q <= 1'b0;
    end
  end
`else
  assign fwd_hit      = 1'b0;
  assign posted_q     = 1'b0;
  assign posted_ack_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      uds_b_q <= 1'b1;
      lds_b_q <= 1'b1;
      wdata_q <= '0;
      wr_word <= '0;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && cpu_req) begin
        addr_q  <= cpu_addr;
        rw_q    <= cpu_rw;
        uds_b_q <= cpu_uds_b;
        lds_b_q <= cpu_lds_b;
        wdata_q <= cpu_wdata;
        wr_word <= cpu_wdata;
      end
      if ((state == RD_ACCESS) && strobe) begin
        if (rw_q) rdata_q <= VRD_in;
        else      wr_word <= byte_merge(VRD_in, wdata_q, uds_b_q, lds_b_q);
      end
      if ((state == ACK) && fwd_hit) rdata_q <= wr_word;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cpu_req)    next_state = no_strobe ? ACK : WAIT_SLOT;
      WAIT_SLOT: if (slot_start) next_state = need_read ? RD_ACCESS : WR_ACCESS;
      RD_ACCESS: if (strobe)     next_state = rw_q ? ACK : RMW_WAIT;
      RMW_WAIT:  if (slot_start) next_state = WR_ACCESS;
      WR_ACCESS: if (strobe)     next_state = ACK;
      ACK:                       next_state = fwd_hit ? ACK : IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // The slot cycle itself is still spent in the waiting state, so strobes are
  // opened combinationally there to cover VRAC=CPU_SLOT..STROBE_SLOT.
  assign rd_phase = (state == RD_ACCESS) ||
                    ((state == WAIT_SLOT) && slot_start && need_read);
  assign wr_phase = (state == WR_ACCESS) ||
                    (slot_start && (((state == WAIT_SLOT) && !need_read) ||
                                    (state == RMW_WAIT)));

  assign MA        = addr_q;
  assign VRAMRD_b  = ~rd_phase;
  assign VRAMWR    = wr_phase;
  assign VRD_oe    = wr_phase;
  assign VRD_out   = wr_word;
  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ((state == ACK) & ~posted_q) | posted_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_cpu_port.sv
// tb_vram_cpu_port : directed scoreboard bench for vram_cpu_port with a
// behavioural VRAM model driven from MA/VRAMWR/VRD_out.
module tb_vram_cpu_port;

  localparam int ADDR_W = 13;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              cpu_req   = 1'b0;
  logic              cpu_rw    = 1'b1;
  logic [ADDR_W-1:0] cpu_addr  = '0;
  logic              cpu_uds_b = 1'b1;
  logic              cpu_lds_b = 1'b1;
  logic [15:0]       cpu_wdata = '0;
  logic [15:0]       cpu_rdata;
  logic              cpu_ack;
  logic [2:0]        VRAC      = 3'd0;
  logic [ADDR_W-1:0] MA;
  logic              VRAMWR, VRAMRD_b, VRD_oe;
  logic [15:0]       VRD_out, VRD_in;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [15:0] mem [0:8191];
  logic        mem_init = 1'b0;

  typedef struct {
    int          ack;
    int          rd_n;
    int          wr_n;
    int          f_rd;
    int          f_wr;
    logic [15:0] rdata;
    logic        chk_rdata;
    logic        timing;
  } exp_t;

  exp_t sb[$];

  vram_cpu_port #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_uds_b (cpu_uds_b),
    .cpu_lds_b (cpu_lds_b),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .VRAC      (VRAC),
    .MA        (MA),
    .VRAMWR    (VRAMWR),
    .VRAMRD_b  (VRAMRD_b),
    .VRD_out   (VRD_out),
    .VRD_oe    (VRD_oe),
    .VRD_in    (VRD_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    VRAC <= VRAC + 3'd1;
    cyc  <= cyc + 1;
  end

  // RAM commits on VRAC=4 (VRAMWR gated by VRAC[2]).
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
      mem[13'h0123] <= 16'hBEEF;
      mem[13'h0200] <= 16'h1234;
      mem[13'h0201] <= 16'h5678;
      mem[13'h0400] <= 16'h7777;
      mem_init      <= 1'b1;
    end else if (VRAMWR && VRD_oe && VRAC[2]) begin
      mem[MA] <= VRD_out;
    end
  end

  assign VRD_in = mem[MA];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_access(input logic rw, input logic [12:0] addr,
                            input logic uds_b, input logic lds_b,
                            input logic [15:0] wdata, input logic [2:0] v_start,
                            input logic scramble, input logic [15:0] known,
                            input logic timing);
    exp_t        e;
    int          c, s, n, ack_c, rd_n, wr_n, f_rd, f_wr;
    logic [15:0] wv;
    logic        seen;
    n = 0;
    while (VRAC !== v_start && n < 16) begin
      @(negedge clk);
      n++;
    end
    c  = cyc;
    s  = (VRAC == 3'd0) ? c + 8 : c + 8 - int'(VRAC);
    wv = {uds_b ? known[15:8] : wdata[15:8], lds_b ? known[7:0] : wdata[7:0]};
    e.ack = c + 1; e.rd_n = 0; e.wr_n = 0; e.f_rd = -1; e.f_wr = -1;
    e.rdata = known; e.chk_rdata = rw & ~(uds_b & lds_b); e.timing = timing;
    if (!(uds_b && lds_b)) begin
      if (rw) begin
        e.ack = s + 5; e.rd_n = 5; e.f_rd = s;
      end
`ifndef VRAM_CPU_POSTED_WRITE_EN
      else if (!uds_b && !lds_b) begin
        e.ack = s + 5; e.wr_n = 5; e.f_wr = s;
      end else begin
        e.ack = s + 13; e.rd_n = 5; e.wr_n = 5; e.f_rd = s; e.f_wr = s + 8;
      end
`endif
    end
    sb.push_back(e);

    cpu_rw = rw; cpu_addr = addr; cpu_uds_b = uds_b; cpu_lds_b = lds_b;
    cpu_wdata = wdata; cpu_req = 1'b1;
    seen = 1'b0; ack_c = -1; rd_n = 0; wr_n = 0; f_rd = -1; f_wr = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (scramble && k == 0) begin
        cpu_addr = ~addr; cpu_wdata = ~wdata; cpu_uds_b = lds_b; cpu_lds_b = uds_b;
      end
      check("rd_wr_exclusive", 32'(~VRAMRD_b & VRAMWR), 32'd0);
      check("oe_during_read", 32'(VRD_oe & ~VRAMRD_b), 32'd0);
      if (!VRAMRD_b) begin
        rd_n++;
        if (f_rd < 0) f_rd = cyc;
        if (timing) check("ma_read", 32'(MA), 32'(addr));
      end
      if (VRAMWR) begin
        wr_n++;
        if (f_wr < 0) f_wr = cyc;
        if (timing) begin
          check("ma_write", 32'(MA), 32'(addr));
          check("vrd_out", 32'(VRD_out), 32'(wv));
          check("vrd_oe", 32'(VRD_oe), 32'd1);
        end
      end
      if (cpu_ack) begin
        seen  = 1'b1;
        ack_c = cyc;
        break;
      end
    end
    cpu_req = 1'b0; cpu_uds_b = 1'b1; cpu_lds_b = 1'b1;

    e = sb.pop_front();
    check("ack_seen", 32'(seen), 32'd1);
    if (seen && e.timing) begin
      check("ack_latency", 32'(ack_c - c), 32'(e.ack - c));
      check("read_cycles", 32'(rd_n), 32'(e.rd_n));
      check("write_cycles", 32'(wr_n), 32'(e.wr_n));
      check("first_read_cyc", 32'(f_rd), 32'(e.f_rd));
      check("first_write_cyc", 32'(f_wr), 32'(e.f_wr));
    end
    if (seen && e.chk_rdata) check("rdata", 32'(cpu_rdata), 32'(e.rdata));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   acks;
    logic found;

    repeat (3) @(negedge clk);
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_ma", 32'(MA), 32'd0);
    check("rst_vramwr", 32'(VRAMWR), 32'd0);
    check("rst_vramrd_b", 32'(VRAMRD_b), 32'd1);
    check("rst_vrd_oe", 32'(VRD_oe), 32'd0);
    check("rst_vrd_out", 32'(VRD_out), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_access(1'b1, 13'h0123, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b0, 16'hBEEF, 1'b1);
    repeat (24) @(negedge clk);
    run_access(1'b0, 13'h0300, 1'b0, 1'b0, 16'h5A5A, 3'd3, 1'b0, 16'h0000, 1'b1);
    repeat (24) @(negedge clk);
    run_access(1'b1, 13'h0300, 1'b0, 1'b0, 16'h0000, 3'd5, 1'b0, 16'h5A5A, 1'b1);
    repeat (24) @(negedge clk);
    run_access(1'b0, 13'h0200, 1'b0, 1'b1, 16'hAB00, 3'd3, 1'b0, 16'h1234, 1'b1);
    repeat (24) @(negedge clk);
    run_access(1'b1, 13'h0200, 1'b0, 1'b0, 16'h0000, 3'd6, 1'b0, 16'hAB34, 1'b1);
    repeat (24) @(negedge clk);
    run_access(1'b0, 13'h0201, 1'b1, 1'b0, 16'h00CD, 3'd3, 1'b0, 16'h5678, 1'b1);
    repeat (24) @(negedge clk);
    run_access(1'b1, 13'h0201, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0, 16'h56CD, 1'b1);
    repeat (24) @(negedge clk);
    // Request on the slot cycle itself waits a full period.
    run_access(1'b1, 13'h0123, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'hBEEF, 1'b1);
    repeat (24) @(negedge clk);
    run_access(1'b1, 13'h0123, 1'b1, 1'b1, 16'h0000, 3'd2, 1'b0, 16'h0000, 1'b1);
    repeat (24) @(negedge clk);
    run_access(1'b1, 13'h0123, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b1, 16'hBEEF, 1'b1);
    repeat (24) @(negedge clk);
    run_access(1'b0, 13'h0500, 1'b0, 1'b0, 16'h1357, 3'd4, 1'b1, 16'h0000, 1'b1);
    repeat (24) @(negedge clk);
    run_access(1'b1, 13'h0500, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h1357, 1'b1);
    repeat (24) @(negedge clk);

    // Abort a word write in mid-strobe with reset.
    while (VRAC !== 3'd3) @(negedge clk);
    cpu_rw = 1'b0; cpu_addr = 13'h0400; cpu_uds_b = 1'b0; cpu_lds_b = 1'b0;
    cpu_wdata = 16'h1111; cpu_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (cpu_ack) cpu_req = 1'b0;
      if (VRAC == 3'd2 && VRAMWR) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_test_reached_write", 32'(found), 32'd1);
    rst = 1'b1; cpu_req = 1'b0; cpu_uds_b = 1'b1; cpu_lds_b = 1'b1;
    #1;
    check("abort_vramwr", 32'(VRAMWR), 32'd0);
    check("abort_vrd_oe", 32'(VRD_oe), 32'd0);
    check("abort_vramrd_b", 32'(VRAMRD_b), 32'd1);
    check("abort_ack", 32'(cpu_ack), 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    check("no_ack_after_abort", 32'(acks), 32'd0);
    run_access(1'b1, 13'h0400, 1'b0, 1'b0, 16'h0000, 3'd7, 1'b0, 16'h7777, 1'b1);
    repeat (24) @(negedge clk);

`ifdef VRAM_CPU_POSTED_WRITE_EN
    run_access(1'b0, 13'h0040, 1'b0, 1'b0, 16'hC0DE, 3'd3, 1'b0, 16'h0000, 1'b1);
    run_access(1'b1, 13'h0040, 1'b0, 1'b0, 16'h0000, VRAC, 1'b0, 16'hC0DE, 1'b0);
    repeat (24) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
